// File: rtl/hog_bridge_ctrl.sv
// hog_bridge_ctrl: HPS bridge slave exposing control/status registers and a HOG result FIFO.
// A transaction is executed once in IDLE; ACK strobes for one cycle and WAIT absorbs a held enable.
module hog_bridge_ctrl #(
    parameter int ADDR_WIDTH = 5,
    parameter int BUS_WIDTH  = 128,
    parameter int BUS_BYTES  = BUS_WIDTH / 8,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic                  bus_enable_i,
    input  logic                  r_wbar_i,
    input  logic [BUS_BYTES-1:0]  byte_enable_i,
    input  logic [BUS_WIDTH-1:0]  write_data_i,
    output logic [BUS_WIDTH-1:0]  read_data_o,
    output logic                  ack_o,
    output logic                  irq_o,
    input  logic [BUS_WIDTH-1:0]  hog_data_i,
    input  logic                  hog_valid_i,
    output logic                  hog_ready_o,
    output logic                  hog_enable_o,
    output logic                  hog_soft_rst_o
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int LW = PW + 1;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ACK  = 2'd1;
    localparam logic [1:0] WAIT = 2'd2;

    logic [1:0]           state_q, state_d;
    logic [31:0]          ctrl_q, ctrl_d;
    logic [3:0]           cmd_q, cmd_d;
    logic [BUS_WIDTH-1:0] rdata_q, rdata_d, rd_val;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [LW-1:0]        level_q, level_d;
    logic                 irq_pend_q, irq_pend_d, unf_q, unf_d;
    logic [BUS_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic                 req, rd, wr, full, empty, push, pop, flush, in_ack, irq_hit;
    logic [8:0]           lvl9, thr;
    logic [31:0]          status;
    logic                 unused_bits;

    assign unused_bits = ^{write_data_i[BUS_WIDTH-1:32], byte_enable_i[BUS_BYTES-1:4]};

    assign req    = state_q == IDLE && bus_enable_i;
    assign rd     = req && r_wbar_i;
    assign wr     = req && !r_wbar_i;
    assign in_ack = state_q == ACK;
    assign full   = level_q == LW'(FIFO_DEPTH);
    assign empty  = level_q == '0;
    // Flush and soft reset both drain the FIFO, so intake is blocked in that ACK cycle.
    assign flush  = in_ack && (cmd_q[0] || cmd_q[1]);
    assign hog_ready_o = !full && !flush;
    assign push   = hog_valid_i && hog_ready_o;
    assign pop    = rd && addr_i == ADDR_WIDTH'(3) && !empty;

    assign lvl9    = 9'(level_q);
    assign thr     = ctrl_q[15:8] == 8'd0 ? 9'd1 : {1'b0, ctrl_q[15:8]};
    assign irq_hit = ctrl_q[1] && lvl9 >= thr;
    assign status  = {12'd0, unf_q, irq_pend_q, empty, full, 7'd0, lvl9};

    assign rd_val = addr_i == ADDR_WIDTH'(0) ? BUS_WIDTH'(status) :
                    addr_i == ADDR_WIDTH'(1) ? BUS_WIDTH'(ctrl_q) :
                    addr_i == ADDR_WIDTH'(3) && !empty ? mem_q[rd_ptr_q] : '0;

    always_comb begin
        ctrl_d = ctrl_q;
        for (int b = 0; b < 4; b++)
            ctrl_d[8*b +: 8] = (wr && addr_i == ADDR_WIDTH'(1) && byte_enable_i[b]) ? write_data_i[8*b +: 8] : ctrl_q[8*b +: 8];
    end

    assign state_d    = state_q == IDLE ? (bus_enable_i ? ACK : IDLE) : (bus_enable_i ? WAIT : IDLE);
    assign cmd_d      = (wr && addr_i == ADDR_WIDTH'(2) && byte_enable_i[0]) ? write_data_i[3:0] : 4'd0;
    assign rdata_d    = req ? (r_wbar_i ? rd_val : '0) : rdata_q;
    assign wr_ptr_d   = flush ? '0 : wr_ptr_q + PW'(push);
    assign rd_ptr_d   = flush ? '0 : rd_ptr_q + PW'(pop);
    assign level_d    = flush ? '0 : level_q + LW'(push) - LW'(pop);
    assign irq_pend_d = (in_ack && cmd_q[2]) ? 1'b0 : irq_pend_q || irq_hit;
    assign unf_d      = (in_ack && cmd_q[3]) ? 1'b0 : unf_q || (rd && addr_i == ADDR_WIDTH'(3) && empty);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            ctrl_q     <= '0;
            cmd_q      <= '0;
            rdata_q    <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            irq_pend_q <= 1'b0;
            unf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            ctrl_q     <= ctrl_d;
            cmd_q      <= cmd_d;
            rdata_q    <= rdata_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            irq_pend_q <= irq_pend_d;
            unf_q      <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem_q[wr_ptr_q] <= hog_data_i;
    end

    assign read_data_o    = rdata_q;
    assign ack_o          = in_ack;
    assign irq_o          = irq_pend_q && ctrl_q[1];
    assign hog_enable_o   = ctrl_q[0];
    assign hog_soft_rst_o = in_ack && cmd_q[0];
endmodule

// File: tb/tb_hog_bridge_ctrl.sv
// tb_hog_bridge_ctrl: scoreboard bench for hog_bridge_ctrl; a queue-based register/FIFO model predicts
// every acked response and a separate monitor compares when ack is presented.
module tb_hog_bridge_ctrl;
    localparam int DEPTH = 16;

    typedef struct packed {
        logic         rd;
        logic [127:0] data;
        logic         srst;
        logic         rdy;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [4:0]   addr = '0;
    logic         bus_enable = 1'b0;
    logic         r_wbar = 1'b0;
    logic [15:0]  byte_enable = '0;
    logic [127:0] write_data = '0;
    logic [127:0] hog_data = '0;
    logic         hog_valid = 1'b0;
    logic [127:0] read_data;
    logic         ack, irq, hog_ready, hog_enable, hog_soft_rst;

    int n_chk = 0;
    int n_fail = 0;
    int ack_cnt = 0;
    int srst_cnt = 0;

    exp_t         exp_q[$];
    exp_t         mon_e;
    logic [127:0] m_q[$];
    logic [31:0]  m_ctrl;
    logic         m_irq, m_unf;

    hog_bridge_ctrl dut (
        .clk(clk), .rst_n(rst_n), .addr_i(addr), .bus_enable_i(bus_enable), .r_wbar_i(r_wbar),
        .byte_enable_i(byte_enable), .write_data_i(write_data), .read_data_o(read_data),
        .ack_o(ack), .irq_o(irq), .hog_data_i(hog_data), .hog_valid_i(hog_valid),
        .hog_ready_o(hog_ready), .hog_enable_o(hog_enable), .hog_soft_rst_o(hog_soft_rst)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [127:0] m_status();
        int l = m_q.size();
        logic [127:0] s = 128'(l);
        if (l == DEPTH) s[16] = 1'b1;
        if (l == 0) s[17] = 1'b1;
        if (m_irq) s[18] = 1'b1;
        if (m_unf) s[19] = 1'b1;
        return s;
    endfunction

    function automatic void update_irq();
        int t = (m_ctrl[15:8] == 8'd0) ? 1 : int'(m_ctrl[15:8]);
        if (m_ctrl[1] && m_q.size() >= t) m_irq = 1'b1;
    endfunction

    function automatic void model_reset();
        m_q.delete();
        m_ctrl = '0;
        m_irq = 1'b0;
        m_unf = 1'b0;
    endfunction

    function automatic logic [127:0] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // Monitor: every ack pops one prediction.
    always @(negedge clk) begin
        if (rst_n && hog_soft_rst) srst_cnt++;
        if (rst_n && ack) begin
            ack_cnt++;
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL unexpected_ack: got ack=1 expected no ack");
            end else begin
                mon_e = exp_q.pop_front();
                if (mon_e.rd) chk("read_data", read_data, mon_e.data);
                chk("soft_rst_at_ack", 128'(hog_soft_rst), 128'(mon_e.srst));
                chk("ready_at_ack", 128'(hog_ready), 128'(mon_e.rdy));
            end
        end
    end

    task automatic push_word(input logic [127:0] d);
        logic acc;
        acc = m_q.size() < DEPTH;
        hog_data = d;
        hog_valid = 1'b1;
        chk("hog_ready", 128'(hog_ready), 128'(acc));
        @(negedge clk);
        hog_valid = 1'b0;
        if (acc) m_q.push_back(d);
        update_irq();
    endtask

    task automatic bus_op(input logic [4:0] a, input logic rw, input logic [15:0] be,
                          input logic [127:0] wd, input int hold, input logic vd);
        exp_t e;
        logic [3:0] cmd;
        int n0, cyc;
        @(negedge clk);
        cmd = 4'd0;
        e = '0;
        e.rd = rw;
        if (rw) begin
            if (a == 5'd0) e.data = m_status();
            else if (a == 5'd1) e.data = 128'(m_ctrl);
            else if (a == 5'd3) begin
                if (m_q.size() == 0) m_unf = 1'b1;
                else e.data = m_q.pop_front();
            end
        end else begin
            if (a == 5'd1)
                for (int b = 0; b < 4; b++)
                    if (be[b]) m_ctrl[8*b +: 8] = wd[8*b +: 8];
            if (a == 5'd2 && be[0]) cmd = wd[3:0];
        end
        if (vd && m_q.size() < DEPTH) m_q.push_back(hog_data);
        e.srst = cmd[0];
        e.rdy = !(cmd[0] || cmd[1]) && m_q.size() < DEPTH;
        if (cmd[0] || cmd[1]) m_q.delete();
        if (cmd[2]) m_irq = 1'b0;
        if (cmd[3]) m_unf = 1'b0;
        update_irq();
        exp_q.push_back(e);
        n0 = ack_cnt;
        addr = a;
        r_wbar = rw;
        byte_enable = be;
        write_data = wd;
        bus_enable = 1'b1;
        hog_valid = vd;
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!ack && cyc < 8);
        chk("ack_latency", 128'(cyc), 128'(1));
        hog_valid = 1'b0;
        repeat (hold) @(negedge clk);
        bus_enable = 1'b0;
        repeat (2) @(negedge clk);
        chk("ack_count", 128'(ack_cnt - n0), 128'(1));
        chk("irq", 128'(irq), 128'(m_irq && m_ctrl[1]));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int r, n0;
        model_reset();
        @(negedge clk);
        chk("rst_read_data", read_data, 128'd0);
        chk("rst_ack", 128'(ack), 128'(0));
        chk("rst_irq", 128'(irq), 128'(0));
        chk("rst_hog_enable", 128'(hog_enable), 128'(0));
        chk("rst_soft_rst", 128'(hog_soft_rst), 128'(0));
        chk("rst_hog_ready", 128'(hog_ready), 128'(1));
        @(negedge clk);
        rst_n = 1'b1;

        bus_op(5'd0, 1'b1, 16'h0, 128'd0, 0, 1'b0);
        bus_op(5'd1, 1'b0, 16'hFFFF, 128'h403, 0, 1'b0);
        chk("hog_enable_set", 128'(hog_enable), 128'(1));
        for (int i = 0; i < 4; i++) push_word(128'hA + 128'(i));
        chk("irq_before_rise", 128'(irq), 128'(0));
        @(negedge clk);
        chk("irq_rise", 128'(irq), 128'(1));
        for (int i = 0; i < 4; i++) bus_op(5'd3, 1'b1, 16'h0, 128'd0, 0, 1'b0);
        chk("irq_held", 128'(irq), 128'(1));
        bus_op(5'd2, 1'b0, 16'h0001, 128'h4, 0, 1'b0);
        chk("irq_cleared", 128'(irq), 128'(0));

        for (int i = 0; i < 17; i++) push_word(128'h100 + 128'(i));
        bus_op(5'd0, 1'b1, 16'h0, 128'd0, 0, 1'b0);
        bus_op(5'd3, 1'b1, 16'h0, 128'd0, 0, 1'b0);
        push_word(128'h200);
        bus_op(5'd0, 1'b1, 16'h0, 128'd0, 0, 1'b0);

        bus_op(5'd2, 1'b0, 16'h0001, 128'h2, 0, 1'b0);
        bus_op(5'd3, 1'b1, 16'h0, 128'd0, 0, 1'b0);
        bus_op(5'd0, 1'b1, 16'h0, 128'd0, 0, 1'b0);
        bus_op(5'd2, 1'b0, 16'h0001, 128'h8, 0, 1'b0);
        bus_op(5'd0, 1'b1, 16'h0, 128'd0, 0, 1'b0);

        for (int i = 0; i < 3; i++) push_word(128'h300 + 128'(i));
        bus_op(5'd3, 1'b1, 16'h0, 128'd0, 4, 1'b0);
        bus_op(5'd0, 1'b1, 16'h0, 128'd0, 0, 1'b0);

        for (int i = 0; i < 3; i++) push_word(128'h400 + 128'(i));
        hog_data = 128'h500;
        n0 = srst_cnt;
        bus_op(5'd2, 1'b0, 16'h0001, 128'h1, 0, 1'b1);
        chk("soft_rst_pulses", 128'(srst_cnt - n0), 128'(1));
        bus_op(5'd0, 1'b1, 16'h0, 128'd0, 0, 1'b0);
        bus_op(5'd1, 1'b1, 16'h0, 128'd0, 0, 1'b0);

        for (int k = 0; k < 300; k++) begin
            r = int'($urandom_range(0, 11));
            if (r <= 3) push_word(rnd128());
            else if (r <= 5) bus_op(5'd3, 1'b1, 16'h0, 128'd0, int'($urandom_range(0, 2)), 1'b0);
            else if (r == 6) bus_op(5'd0, 1'b1, 16'h0, 128'd0, int'($urandom_range(0, 2)), 1'b0);
            else if (r == 7) begin
                logic [127:0] wd = rnd128();
                wd[15:8] = 8'($urandom_range(0, 17));
                bus_op(5'd1, 1'b0, 16'($urandom_range(0, 65535)), wd, int'($urandom_range(0, 2)), 1'b0);
            end
            else if (r == 8) bus_op(5'd1, 1'b1, 16'h0, 128'd0, 0, 1'b0);
            else if (r == 9) bus_op(5'd2, 1'b0, 16'($urandom_range(0, 65535)), 128'($urandom_range(0, 15)), int'($urandom_range(0, 2)), 1'b0);
            else if (r == 10) bus_op(5'($urandom_range(4, 31)), 1'b1, 16'h0, 128'd0, 0, 1'b0);
            else bus_op(5'($urandom_range(4, 31)), 1'b0, 16'hFFFF, rnd128(), 0, 1'b0);
        end

        // Reset lands after the request was captured but before its ack.
        n0 = ack_cnt;
        @(negedge clk);
        addr = 5'd0;
        r_wbar = 1'b1;
        bus_enable = 1'b1;
        @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk);
        chk("ack_in_reset", 128'(ack), 128'(0));
        bus_enable = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        @(negedge clk);
        chk("no_ack_after_reset", 128'(ack_cnt - n0), 128'(0));
        chk("hog_enable_after_reset", 128'(hog_enable), 128'(0));
        bus_op(5'd0, 1'b1, 16'h0, 128'd0, 0, 1'b0);
        bus_op(5'd1, 1'b1, 16'h0, 128'd0, 0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
